// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S link: receiver state encoding, slot polarity
// and the default word length used by both transmitter and receiver.
package i2s_pkg;
  typedef enum logic [1:0] {HUNT, DELAY, SHIFT, WAIT} rx_state_t;
  localparam logic LEFT_SLOT        = 1'b0;
  localparam int   DEFAULT_WORD_LEN = 16;
endpackage

// File: rtl/i2s_rx_sync.sv
// Synchronises frame_clk, bit_clk and data into clk, then registers one more
// stage so bit_rise, ws_level and data_s are mutually aligned.
module i2s_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_clk,
  input  logic bit_clk,
  input  logic data,
  output logic bit_rise,
  output logic ws_level,
  output logic data_s
);
  // Each stage packs {frame_clk, bit_clk, data} so all three see equal delay.
  logic [2:0] sync_sr [SYNC_STAGES];
  logic [2:0] synced;
  logic       bclk_d;

  assign synced = sync_sr[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_sr[i] <= 3'b000;
      bclk_d   <= 1'b0;
      bit_rise <= 1'b0;
      ws_level <= 1'b0;
      data_s   <= 1'b0;
    end else begin
      sync_sr[0] <= {frame_clk, bit_clk, data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_sr[i] <= sync_sr[i-1];
      bclk_d   <= synced[1];
      bit_rise <= synced[1] & ~bclk_d;
      ws_level <= synced[2];
      data_s   <= synced[0];
    end
  end
endmodule

// File: rtl/i2s_rx.sv
// Philips I2S receiver: hunts for a word-select edge, captures up to WIDTH
// bits MSB first per slot and commits left-aligned words with one-cycle strobes.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WORD_LEN,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       word_length,
  input  logic             frame_clk,
  input  logic             bit_clk,
  input  logic             data,
  output logic [WIDTH-1:0] recv_left,
  output logic [WIDTH-1:0] recv_right,
  output logic             left_valid,
  output logic             right_valid,
  output logic             sync_error,
  output rx_state_t        rx_state
);
  localparam int CW = $clog2(WIDTH + 1);

  logic bit_rise, ws_level, data_s;

  i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .frame_clk (frame_clk),
    .bit_clk   (bit_clk),
    .data      (data),
    .bit_rise  (bit_rise),
    .ws_level  (ws_level),
    .data_s    (data_s)
  );

  rx_state_t        state, state_next;
  logic             ws_last, primed, ws_edge, slot;
  logic             commit_q, commit_slot;
  logic [CW-1:0]    bit_cnt, eff_len, len_in;
  logic [WIDTH-1:0] shift, mask;
  logic             start_slot, take_first, take_bit, word_done, short_err;

  assign rx_state = state;
  // primed keeps the first bit_rise after reset from reporting a phantom edge.
  assign ws_edge  = bit_rise && primed && (ws_level != ws_last);

  always_comb begin
    len_in = CW'(word_length);
    if ((word_length == 8'd0) || (32'(word_length) > WIDTH)) len_in = CW'(WIDTH);
  end

  always_comb begin
    state_next = state;
    start_slot = 1'b0;
    take_first = 1'b0;
    take_bit   = 1'b0;
    word_done  = 1'b0;
    short_err  = 1'b0;
    case (state)
      HUNT: if (ws_edge) begin
        state_next = DELAY;
        start_slot = 1'b1;
      end
      DELAY: if (bit_rise) begin
        if (eff_len == CW'(1)) begin
          take_first = 1'b1;
          word_done  = 1'b1;
          start_slot = ws_edge;
          state_next = ws_edge ? DELAY : WAIT;
        end else if (ws_edge) begin
          short_err  = 1'b1;
          start_slot = 1'b1;
        end else begin
          take_first = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: if (bit_rise) begin
        // A word-select edge on the final bit is the normal Philips framing.
        if (bit_cnt + CW'(1) == eff_len) begin
          take_bit   = 1'b1;
          word_done  = 1'b1;
          start_slot = ws_edge;
          state_next = ws_edge ? DELAY : WAIT;
        end else if (ws_edge) begin
          short_err  = 1'b1;
          start_slot = 1'b1;
          state_next = DELAY;
        end else begin
          take_bit   = 1'b1;
        end
      end
      WAIT: if (ws_edge) begin
        state_next = DELAY;
        start_slot = 1'b1;
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      ws_last     <= 1'b0;
      primed      <= 1'b0;
      slot        <= LEFT_SLOT;
      eff_len     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      mask        <= '0;
      commit_q    <= 1'b0;
      commit_slot <= LEFT_SLOT;
      recv_left   <= '0;
      recv_right  <= '0;
      left_valid  <= 1'b0;
      right_valid <= 1'b0;
      sync_error  <= 1'b0;
    end else begin
      state <= state_next;
      if (bit_rise) begin
        ws_last <= ws_level;
        primed  <= 1'b1;
      end
      if (start_slot) begin
        slot    <= ws_level;
        eff_len <= len_in;
      end
      // mask walks a single 1 down from the MSB, keeping capture left-aligned.
      if (take_first) begin
        shift   <= {data_s, {(WIDTH-1){1'b0}}};
        mask    <= {{(WIDTH-1){1'b0}}, 1'b1} << (WIDTH - 2);
        bit_cnt <= CW'(1);
      end else if (take_bit) begin
        if (data_s) shift <= shift | mask;
        mask    <= mask >> 1;
        bit_cnt <= bit_cnt + CW'(1);
      end
      commit_q    <= word_done;
      commit_slot <= slot;
      left_valid  <= commit_q && (commit_slot == LEFT_SLOT);
      right_valid <= commit_q && (commit_slot != LEFT_SLOT);
      if (commit_q) begin
        if (commit_slot == LEFT_SLOT) recv_left  <= shift;
        else                          recv_right <= shift;
      end
      sync_error <= short_err;
    end
  end
endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: builds Philips I2S bit streams, plays them on the
// pins and compares committed words, strobes and latency against hand values.
module tb_i2s_rx;
  import i2s_pkg::*;
  localparam int WIDTH = 16;
  localparam int SYNC_STAGES = 2;

  logic             clk, reset;
  logic [7:0]       word_length;
  logic             frame_clk, bit_clk, data;
  logic [WIDTH-1:0] recv_left, recv_right;
  logic             left_valid, right_valid, sync_error;
  rx_state_t        rx_state;

  i2s_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .word_length(word_length),
    .frame_clk(frame_clk), .bit_clk(bit_clk), .data(data),
    .recv_left(recv_left), .recv_right(recv_right),
    .left_valid(left_valid), .right_valid(right_valid),
    .sync_error(sync_error), .rx_state(rx_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  // stream to play: slot level and data per bit, plus pin rise cycles
  logic bit_ws[$];
  logic bit_d[$];
  int   rise_at[$];

  // scoreboard: expected {side, word}; observed events from the monitor
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] ev_q[$];
  int             ev_cyc[$];
  int             err_cnt = 0;
  int             overlap = 0;
  logic [WIDTH-1:0] err_left;

  always @(posedge clk) begin
    #1;
    if (left_valid && right_valid) overlap++;
    if (left_valid) begin
      ev_q.push_back({1'b0, recv_left});
      ev_cyc.push_back(cyc);
    end
    if (right_valid) begin
      ev_q.push_back({1'b1, recv_right});
      ev_cyc.push_back(cyc);
    end
    if (sync_error) begin
      err_cnt++;
      err_left = recv_left;
    end
  end

  // driver tasks
  task automatic do_reset(input logic ws);
    @(negedge clk);
    reset = 1'b1; bit_clk = 1'b0; frame_clk = ws; data = 1'($urandom);
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_all();
    bit_ws.delete(); bit_d.delete(); rise_at.delete();
    exp_q.delete(); ev_q.delete(); ev_cyc.delete();
    err_cnt = 0; overlap = 0;
  endtask

  task automatic push_slot(input logic ws, input logic [31:0] word, input int nbits);
    for (int k = nbits - 1; k >= 0; k--) begin
      bit_ws.push_back(ws);
      bit_d.push_back(word[k]);
    end
  endtask

  task automatic push_rand(input logic ws, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      bit_ws.push_back(ws);
      bit_d.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  // Word select leads data by one bit, as on a Philips bus.
  task automatic play(input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      @(negedge clk);
      bit_clk   = 1'b0;
      frame_clk = (i + 1 < bit_ws.size()) ? bit_ws[i+1] : bit_ws[i];
      data      = bit_d[i];
      repeat (4) @(negedge clk);
      bit_clk = 1'b1;
      rise_at.push_back(cyc + 1);
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic compare_events(input string name);
    logic [WIDTH:0] got;
    checks++;
    if (ev_q.size() !== exp_q.size())
      $display("FAIL %s count: got %0d events, expected %0d", name, ev_q.size(), exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size(); i++) begin
      got = 'x;
      if (i < ev_q.size()) got = ev_q[i];
      checks++;
      if (got !== exp_q[i])
        $display("FAIL %s event %0d: got side/word %h, expected %h", name, i, got, exp_q[i]);
      else passes++;
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (recv_left !== 16'h0000) $display("FAIL %s recv_left: got %h expected 0000", name, recv_left);
    else passes++;
    checks++;
    if (recv_right !== 16'h0000) $display("FAIL %s recv_right: got %h expected 0000", name, recv_right);
    else passes++;
    checks++;
    if ({left_valid, right_valid, sync_error} !== 3'b000)
      $display("FAIL %s strobes: got %b expected 000", name, {left_valid, right_valid, sync_error});
    else passes++;
  endtask

  // scenarios
  task automatic test_reset();
    word_length = 8'd16;
    do_reset(1'b0);
    @(posedge clk); #1;
    check_outputs_zero("reset");
    checks++;
    if (rx_state !== HUNT) $display("FAIL reset state: got %0d expected %0d", rx_state, HUNT);
    else passes++;
  endtask

  task automatic test_loopback();
    clear_all();
    word_length = 8'd16;
    push_rand(1'b1, 16);
    push_slot(1'b0, 32'h8000, 16); push_slot(1'b1, 32'h7FFF, 16);
    push_slot(1'b0, 32'h8000, 16); push_slot(1'b1, 32'h7FFF, 16);
    exp_q = '{17'h08000, 17'h17FFF, 17'h08000, 17'h17FFF};
    play(0, bit_ws.size());
    settle();
    compare_events("loopback");
    checks++;
    if (overlap !== 0) $display("FAIL loopback overlap: got %0d cycles with both valids, expected 0", overlap);
    else passes++;
    checks++;
    if (err_cnt !== 0) $display("FAIL loopback sync_error: got %0d pulses, expected 0", err_cnt);
    else passes++;
  endtask

  task automatic test_short_word();
    clear_all();
    word_length = 8'd8;
    push_rand(1'b1, 16);
    push_slot(1'b0, 32'hA5C3, 16);
    push_slot(1'b1, 32'h3CFF, 16);
    exp_q = '{17'h0A500, 17'h13C00};
    play(0, bit_ws.size());
    settle();
    compare_events("short_word");
  endtask

  task automatic test_truncated();
    clear_all();
    word_length = 8'd16;
    push_rand(1'b1, 16);
    push_slot(1'b0, 32'h03FF, 10);
    push_slot(1'b1, 32'h1234, 16);
    push_slot(1'b0, 32'hBEEF, 16);
    exp_q = '{17'h11234, 17'h0BEEF};
    play(0, bit_ws.size());
    settle();
    checks++;
    if (err_cnt !== 1) $display("FAIL truncated sync_error: got %0d pulses, expected 1", err_cnt);
    else passes++;
    checks++;
    if (err_left !== 16'hA500) $display("FAIL truncated recv_left held: got %h expected a500", err_left);
    else passes++;
    compare_events("truncated");
  endtask

  task automatic test_startup();
    clear_all();
    word_length = 8'd16;
    do_reset(1'b1);
    push_rand(1'b1, 5);
    push_slot(1'b0, 32'hC0DE, 16);
    push_slot(1'b1, 32'h0F0F, 16);
    exp_q = '{17'h0C0DE, 17'h10F0F};
    play(0, bit_ws.size());
    settle();
    compare_events("startup");
  endtask

  task automatic test_reset_mid_word();
    clear_all();
    word_length = 8'd16;
    push_rand(1'b1, 16);
    push_slot(1'b0, 32'h1111, 16);
    push_slot(1'b1, 32'h2222, 16);
    play(0, 39);
    checks++;
    if (recv_left !== 16'h1111) $display("FAIL midreset pre recv_left: got %h expected 1111", recv_left);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    clear_all();
    push_slot(1'b1, 32'h2222, 9);
    push_slot(1'b0, 32'h3333, 16);
    push_slot(1'b1, 32'h4444, 16);
    exp_q = '{17'h03333, 17'h14444};
    play(0, bit_ws.size());
    settle();
    compare_events("midreset resume");
  endtask

  task automatic test_clamp_latency(input logic [7:0] wl, input logic [15:0] lw, input logic [15:0] rw);
    clear_all();
    word_length = wl;
    push_rand(1'b1, 16);
    push_slot(1'b0, {16'h0, lw}, 16);
    push_slot(1'b1, {16'h0, rw}, 16);
    exp_q = '{{1'b0, lw}, {1'b1, rw}};
    play(0, bit_ws.size());
    settle();
    compare_events($sformatf("clamp wl=%0d", wl));
    checks++;
    if (ev_cyc.size() < 2 || ev_cyc[0] !== rise_at[31] + SYNC_STAGES + 2)
      $display("FAIL latency left wl=%0d: got cycle %0d expected %0d", wl,
               (ev_cyc.size() > 0) ? ev_cyc[0] : -1, rise_at[31] + SYNC_STAGES + 2);
    else passes++;
    checks++;
    if (ev_cyc.size() < 2 || ev_cyc[1] !== rise_at[47] + SYNC_STAGES + 2)
      $display("FAIL latency right wl=%0d: got cycle %0d expected %0d", wl,
               (ev_cyc.size() > 1) ? ev_cyc[1] : -1, rise_at[47] + SYNC_STAGES + 2);
    else passes++;
  endtask

  initial begin
    reset = 1'b1; word_length = 8'd16;
    frame_clk = 1'b0; bit_clk = 1'b0; data = 1'b0;
    test_reset();
    test_loopback();
    test_short_word();
    test_truncated();
    test_startup();
    test_reset_mid_word();
    test_clamp_latency(8'd0,  16'h9C31, 16'h6E2D);
    test_clamp_latency(8'd40, 16'hF00D, 16'h0001);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Receive side of the team's I2S link: deserialises frame_clk / bit_clk / data back into left and right PCM words.
- Used to loop back the synth's i2s output for self-check, and to accept external I2S sources such as an ADC or codec.
- All inputs are sampled in the single system clock domain.
- Outputs are registered words plus one-cycle strobes.

Parameters:
- WIDTH, 16, width of recv_left / recv_right in bits.
- SYNC_STAGES, 2, number of synchroniser flops applied to frame_clk, bit_clk and data.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- word_length  input  8  bits per channel slot to capture, MSB first
- frame_clk  input  1  I2S word select; 0 = left slot, 1 = right slot
- bit_clk  input  1  I2S serial clock; data is sampled on its rising edge
- data  input  1  I2S serial data
- recv_left  output  WIDTH  last completed left word
- recv_right  output  WIDTH  last completed right word
- left_valid  output  1  one-cycle strobe; recv_left updated this cycle
- right_valid  output  1  one-cycle strobe; recv_right updated this cycle
- sync_error  output  1  one-cycle strobe; a slot ended before word_length bits were captured

Behaviour:
- Clock ratio: clk must be at least 4x bit_clk frequency. bit_clk and frame_clk are treated as data; no second clock domain exists.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops.
  - One further register feeds edge detection.
  - bit_rise = synced bit_clk 0->1. ws_edge = synced frame_clk changed since last bit_rise.
- Format is Philips I2S:
  - The frame_clk transition is seen on a bit_rise.
  - The MSB is sampled on the following bit_rise (one-bit delay).
  - Remaining bits follow, MSB first.
- Effective length: eff_len = word_length, except word_length = 0 or word_length > WIDTH gives eff_len = WIDTH. word_length is latched at each slot start.
- Alignment:
  - Captured words are left-aligned (first bit lands in bit WIDTH-1).
  - Unfilled low bits are 0.
  - Bits after eff_len within a slot are ignored.
- State machine:
  - HUNT (reset state): wait for the first ws_edge on a bit_rise, then go to DELAY. Data before the first edge is discarded.
  - DELAY: on next bit_rise, shift in bit 1 of the slot, bit_cnt = 1, go to SHIFT.
  - SHIFT: on each bit_rise, shift data into the shift register and bit_cnt++. When bit_cnt reaches eff_len:
    - commit the word to recv_left (slot frame_clk = 0) or recv_right (slot frame_clk = 1);
    - pulse the matching valid the next clk;
    - go to WAIT.
  - WAIT: ignore bits until ws_edge, then go to DELAY with the opposite slot.
- Early slot end: a ws_edge seen in SHIFT means the slot ended short.
  - Discard the partial word; outputs are not updated and no valid pulses.
  - Pulse sync_error for 1 cycle.
  - Go to DELAY for the new slot.
- Simultaneous events: a ws_edge on the same bit_rise that captures bit eff_len counts as a complete word; commit, no error, then DELAY.
- Latency: valid asserts exactly SYNC_STAGES + 2 clk cycles after the clk edge that first samples the pin-level LSB rising bit_clk.
- Data and valid: recv_* hold their value until the next commit. Valid and data change in the same cycle.
- Reset:
  - recv_left = recv_right = 0; left_valid = right_valid = sync_error = 0.
  - Synchroniser flops cleared; state = HUNT; bit_cnt = 0; shift register = 0.
  - Reset mid-word drops the word, and reception resumes only after a fresh frame_clk edge.
- left_valid and right_valid are never high in the same cycle.

Decomposition:
- Shared package i2s_pkg holds:
  - rx state enum (HUNT, DELAY, SHIFT, WAIT);
  - constant for the slot-select polarity (LEFT_SLOT = 0);
  - default word length constant (16), shared with the existing i2s transmitter.
- One natural sub-module, i2s_rx_sync: a parameterised SYNC_STAGES synchroniser plus edge detector. It outputs bit_rise, ws_level and data_s. The top holds the FSM and shifter.

Test Plan:
- Loopback from the existing i2s transmitter: word_length = 16, left = 16'h8000, right = 16'h7FFF. Expect first left_valid with recv_left = 16'h8000, then right_valid with recv_right = 16'h7FFF, repeating each frame.
- Short word: word_length = 8, bench drives 0xA5 in a 16-bit slot. Expect recv_left = 16'hA500, low byte zero; the trailing 8 bits are ignored.
- Truncated slot: word_length = 16, frame_clk toggles after 10 bits. Expect a sync_error pulse, no valid, recv unchanged; the next full slot is received correctly.
- Start-up: release reset mid-frame with random data on the line. Expect no valid until after the first frame_clk edge; the first captured word is exact.
- Reset mid-word: assert reset during bit 7 of a right slot. Expect all outputs 0 the next cycle; the partial word is never committed.
- Latency and clamp: word_length = 0 and word_length = 40 with WIDTH = 16. Expect 16-bit capture in both cases, with valid exactly SYNC_STAGES + 2 cycles after the LSB bit_clk rise.
